gbe_read_depacketizer: RTL and testbench

GBE_READ_DEPACKETIZER -- requirements
Module: gbe_read_depacketizer

---
 rtl/gbe_pkt_pkg.sv | 21 ++
 rtl/gbe_read_depacketizer_if.sv | 33 +++
 rtl/gbe_rx_sipo.sv | 100 ++++++++++
 rtl/gbe_read_depacketizer.sv | 132 +++++++++++++
 tb/tb_gbe_read_depacketizer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gbe_pkt_pkg.sv
// Shared definitions for the GbE packet read/write paths: FSM state
// encoding and the word-geometry helpers derived from the output width.
package gbe_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_e;

    // Bytes per output word.
    function automatic int calc_bpw(input int dout_width);
        return dout_width / 8;
    endfunction

    // Width of the byte-within-word index; never narrower than one bit.
    function automatic int calc_idx_w(input int dout_width);
        return (dout_width / 8 > 1) ? $clog2(dout_width / 8) : 1;
    endfunction

endpackage

// File: rtl/gbe_read_depacketizer_if.sv
// Byte stream in / word stream out bundle of the read depacketizer.
//
// Handshake: there is no ready in either direction. rx_valid qualifies
// rx_data/rx_eof/rx_bad_frame/rx_source_ip for exactly the cycle it is
// high and the byte is always consumed that cycle. dout_valid is a
// single-cycle pulse qualifying dout/dout_sof/dout_eof/dout_err; the sink
// must take the word that cycle. dout_err is meaningful only with dout_eof.
interface gbe_read_depacketizer_if #(
    parameter int DOUT_WIDTH = 128
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_eof;
    logic                  rx_bad_frame;
    logic [31:0]           rx_source_ip;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_sof;
    logic                  dout_eof;
    logic                  dout_err;

    // Byte source / word sink side.
    modport master (
        output rx_data, rx_valid, rx_eof, rx_bad_frame, rx_source_ip,
        input  dout, dout_valid, dout_sof, dout_eof, dout_err
    );

    // Depacketizer side.
    modport slave (
        input  rx_data, rx_valid, rx_eof, rx_bad_frame, rx_source_ip,
        output dout, dout_valid, dout_sof, dout_eof, dout_err
    );
endinterface

// File: rtl/gbe_rx_sipo.sv
// Byte-to-word assembler: places bytes MSB-first into a word, emits the
// word one cycle after it fills or after the packet's last byte, and pads
// the unfilled tail of a short final word with zeros.
module gbe_rx_sipo
    import gbe_pkt_pkg::*;
#(
    parameter int DOUT_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_err,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_sof,
    output logic                  dout_eof,
    output logic                  dout_err
);
    localparam int BPW   = calc_bpw(DOUT_WIDTH);
    localparam int IDX_W = calc_idx_w(DOUT_WIDTH);

    logic [IDX_W-1:0]      idx_q, idx_d, idx_cur;
    logic [DOUT_WIDTH-1:0] word_q, word_d, word_next;
    logic                  sof_pend_q, sof_pend_d, sof_cur;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_sof_q, dout_sof_d;
    logic                  dout_eof_q, dout_eof_d;
    logic                  dout_err_q, dout_err_d;

    // Drop the byte into its slot; flush the word when full or at eof.
    always_comb begin
        idx_d        = idx_q;
        word_d       = word_q;
        sof_pend_d   = sof_pend_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_sof_d   = 1'b0;
        dout_eof_d   = 1'b0;
        dout_err_d   = 1'b0;
        // A first byte always restarts assembly from an empty word.
        idx_cur      = in_first ? '0 : idx_q;
        word_next    = in_first ? '0 : word_q;
        sof_cur      = in_first | sof_pend_q;
        for (int k = 0; k < BPW; k++) begin
            if (idx_cur == IDX_W'(k)) begin
                word_next[DOUT_WIDTH-1-8*k -: 8] = in_data;
            end
        end
        if (in_valid) begin
            if (in_last || idx_cur == IDX_W'(BPW - 1)) begin
                dout_d       = word_next;
                dout_valid_d = 1'b1;
                dout_sof_d   = sof_cur;
                dout_eof_d   = in_last;
                dout_err_d   = in_last & in_err;
                idx_d        = '0;
                word_d       = '0;
                sof_pend_d   = 1'b0;
            end else begin
                idx_d        = idx_cur + IDX_W'(1);
                word_d       = word_next;
                sof_pend_d   = sof_cur;
            end
        end
    end

    // Assembly state and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            word_q       <= '0;
            sof_pend_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
            dout_err_q   <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            word_q       <= word_d;
            sof_pend_q   <= sof_pend_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
            dout_eof_q   <= dout_eof_d;
            dout_err_q   <= dout_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign dout_eof   = dout_eof_q;
    assign dout_err   = dout_err_q;

endmodule

// File: rtl/gbe_read_depacketizer.sv
// GbE read-path depacketizer: filters packets by source IP, checks length
// and MAC status at eof, keeps status counters, and hands accepted bytes to
// the word assembler.
module gbe_read_depacketizer
    import gbe_pkt_pkg::*;
#(
    parameter int DOUT_WIDTH = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    gbe_read_depacketizer_if.slave        bus,
    input  logic [31:0]                   config_pkt_len,
    input  logic [31:0]                   config_src_ip,
    input  logic                          config_filter_en,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   err_count,
    output logic [31:0]                   drop_count,
    output state_e                        dbg_state
);
    state_e      state_q, state_d;
    logic [31:0] byte_cnt_q, byte_cnt_d, cnt_inc;
    logic [31:0] cfg_len_q, cfg_len_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] err_count_q, err_count_d;
    logic [31:0] drop_count_q, drop_count_d;
    logic        sipo_valid, sipo_first, sipo_last, sipo_err;

    // Packet FSM, length/status checks and counter updates.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        cfg_len_d    = cfg_len_q;
        pkt_count_d  = pkt_count_q;
        err_count_d  = err_count_q;
        drop_count_d = drop_count_q;
        sipo_valid   = 1'b0;
        sipo_first   = 1'b0;
        sipo_last    = 1'b0;
        sipo_err     = 1'b0;
        // Byte count saturates rather than wrapping on absurdly long packets.
        cnt_inc      = (byte_cnt_q == 32'hFFFF_FFFF) ? byte_cnt_q : byte_cnt_q + 32'd1;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (config_filter_en && (bus.rx_source_ip != config_src_ip)) begin
                        drop_count_d = drop_count_q + 32'd1;
                        state_d      = bus.rx_eof ? IDLE : DROP;
                    end else begin
                        // Config is latched here so mid-packet edits wait for the next packet.
                        cfg_len_d  = config_pkt_len;
                        byte_cnt_d = 32'd1;
                        sipo_valid = 1'b1;
                        sipo_first = 1'b1;
                        sipo_last  = bus.rx_eof;
                        // 33-bit compare: a length field of all ones can never match.
                        sipo_err   = bus.rx_bad_frame ||
                                     (33'd1 != ({1'b0, config_pkt_len} + 33'd1));
                        state_d    = bus.rx_eof ? IDLE : RECV;
                    end
                end
            end
            RECV: begin
                if (bus.rx_valid) begin
                    byte_cnt_d = cnt_inc;
                    sipo_valid = 1'b1;
                    sipo_last  = bus.rx_eof;
                    sipo_err   = bus.rx_bad_frame ||
                                 ({1'b0, cnt_inc} != ({1'b0, cfg_len_q} + 33'd1));
                    if (bus.rx_eof) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (bus.rx_valid && bus.rx_eof) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Counters move in the same cycle the eof word is registered.
        if (sipo_valid && sipo_last) begin
            if (sipo_err) begin
                err_count_d = err_count_q + 32'd1;
            end else begin
                pkt_count_d = pkt_count_q + 32'd1;
            end
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            cfg_len_q    <= '0;
            pkt_count_q  <= '0;
            err_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            cfg_len_q    <= cfg_len_d;
            pkt_count_q  <= pkt_count_d;
            err_count_q  <= err_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    gbe_rx_sipo #(
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_sipo (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (sipo_valid),
        .in_data    (bus.rx_data),
        .in_first   (sipo_first),
        .in_last    (sipo_last),
        .in_err     (sipo_err),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .dout_sof   (bus.dout_sof),
        .dout_eof   (bus.dout_eof),
        .dout_err   (bus.dout_err)
    );

    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;
    assign drop_count = drop_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gbe_read_depacketizer.sv
// Directed bench for gbe_read_depacketizer with a packet-level model:
// each packet is chopped into zero-padded words with sof/eof/err flags
// and the due cycle of every word is queued for the compare process.
module tb_gbe_read_depacketizer;
    import gbe_pkt_pkg::*;

    localparam int W   = 128;
    localparam int BPW = W / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] config_pkt_len;
    logic [31:0] config_src_ip;
    logic        config_filter_en;
    logic [31:0] pkt_count, err_count, drop_count;
    state_e      dbg_state;

    gbe_read_depacketizer_if #(.DOUT_WIDTH(W)) bus ();

    gbe_read_depacketizer #(.DOUT_WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .config_pkt_len   (config_pkt_len),
        .config_src_ip    (config_src_ip),
        .config_filter_en (config_filter_en),
        .pkt_count        (pkt_count),
        .err_count        (err_count),
        .drop_count       (drop_count),
        .dbg_state        (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    // Entry layout: {err, eof, sof, dout}
    logic [W+2:0] exp_q[$];
    int           exp_cyc[$];
    logic [7:0]   pkt_buf[$];
    int           total = 0;
    int           bad   = 0;
    int           exp_pkt = 0, exp_err = 0, exp_drop = 0;
    localparam logic [31:0] GOOD_IP = 32'hC0A8_0001;

    task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- model ----------------
    task automatic fill_seq(input int len, input int base);
        pkt_buf.delete();
        for (int i = 0; i < len; i++) pkt_buf.push_back(8'(base + i));
    endtask

    task automatic model_pkt(input int len, input bit bad_frame, input logic [31:0] cfg_len);
        int           nwords;
        bit           err;
        logic [W-1:0] word;
        nwords = (len + BPW - 1) / BPW;
        err    = bad_frame || (longint'(len) != longint'(cfg_len) + 64'd1);
        for (int w = 0; w < nwords; w++) begin
            bit last;
            word = '0;
            for (int b = 0; b < BPW; b++) begin
                if (w * BPW + b < len) word[W-1-8*b -: 8] = pkt_buf[w * BPW + b];
            end
            last = (w == nwords - 1);
            exp_q.push_back({last & err, last, (w == 0), word});
        end
        if (err) exp_err++;
        else     exp_pkt++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives bytes [0, n_drive) of pkt_buf as a packet of length len.
    task automatic drive_pkt(input int len, input logic [31:0] ip, input bit bad_frame,
                             input bit gaps, input bit expect_out, input int n_drive,
                             input int cfg_flip_at);
        for (int i = 0; i < n_drive; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            bus.rx_valid     = 1'b1;
            bus.rx_data      = pkt_buf[i];
            bus.rx_eof       = (i == len - 1);
            bus.rx_bad_frame = (i == len - 1) ? bad_frame : 1'($urandom_range(0, 1));
            bus.rx_source_ip = (i == 0) ? ip : $urandom;
            if (i == cfg_flip_at) begin
                config_pkt_len = 32'd5;
                config_src_ip  = $urandom;
            end
            if (expect_out && ((i % BPW == BPW - 1) || (i == len - 1))) exp_cyc.push_back(cyc + 1);
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
            bus.rx_eof   = 1'b0;
        end
    endtask

    // Reset pulse with junk bytes offered while rst is high.
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'($urandom);
            bus.rx_eof   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        bus.rx_eof   = 1'b0;
        rst          = 1'b0;
        exp_pkt = 0; exp_err = 0; exp_drop = 0;
    endtask

    task automatic check_counters(input string name);
        check({name, "_pkt"},   pkt_count,      exp_pkt);
        check({name, "_err"},   err_count,      exp_err);
        check({name, "_drop"},  drop_count,     exp_drop);
        check({name, "_drain"}, exp_q.size(),   0);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst && bus.dout_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word actual=%h required=none", bus.dout);
            end else begin
                logic [W+2:0] e;
                int           c;
                e = exp_q.pop_front();
                c = exp_cyc.pop_front();
                if ({bus.dout_err, bus.dout_eof, bus.dout_sof, bus.dout} !== e || cyc != c) begin
                    bad++;
                    $display("FAIL word actual=%h@%0d required=%h@%0d",
                             {bus.dout_err, bus.dout_eof, bus.dout_sof, bus.dout}, cyc, e, c);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.rx_valid = 0; bus.rx_data = 0; bus.rx_eof = 0;
        bus.rx_bad_frame = 0; bus.rx_source_ip = GOOD_IP;
        config_pkt_len = 32'd31; config_src_ip = GOOD_IP; config_filter_en = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_valid", bus.dout_valid, 0);
        check("rst_dout",  bus.dout, 0);
        check("rst_flags", {bus.dout_sof, bus.dout_eof, bus.dout_err}, 0);
        check("rst_state", dbg_state, IDLE);
        check_counters("rst");

        // Good 32-byte packet, continuous
        fill_seq(32, 0);
        model_pkt(32, 0, 32'd31);
        check("pin_t1_w0", exp_q[0], {3'b001, 128'h000102030405060708090a0b0c0d0e0f});
        check("pin_t1_w1", exp_q[1], {3'b010, 128'h101112131415161718191a1b1c1d1e1f});
        drive_pkt(32, GOOD_IP, 0, 0, 1, 32, -1);
        idle(4);
        check("t1_pkt_lit", pkt_count, 1);
        check_counters("t1");

        // 20-byte packet with gaps: length mismatch
        do_reset();
        fill_seq(20, 0);
        model_pkt(20, 0, 32'd31);
        check("pin_t2_w1", exp_q[1], {3'b110, 32'h10111213, 96'h0});
        drive_pkt(20, GOOD_IP, 0, 1, 1, 20, -1);
        idle(4);
        check("t2_err_lit", err_count, 1);
        check_counters("t2");

        // 32-byte packet, bad frame flagged on eof
        do_reset();
        fill_seq(32, 0);
        model_pkt(32, 1, 32'd31);
        drive_pkt(32, GOOD_IP, 1, 0, 1, 32, -1);
        idle(4);
        check("t3_err_lit", err_count, 1);
        check_counters("t3");

        // Filtered packet then back-to-back matching packet
        do_reset();
        config_filter_en = 1'b1;
        fill_seq(32, 8'h40);
        exp_drop++;
        drive_pkt(32, 32'h0A00_0001, 0, 0, 0, 32, -1);
        fill_seq(32, 8'h80);
        model_pkt(32, 0, 32'd31);
        drive_pkt(32, GOOD_IP, 0, 0, 1, 32, -1);
        idle(4);
        check("t4_drop_lit", drop_count, 1);
        check_counters("t4");
        config_filter_en = 1'b0;

        // Reset mid-packet after byte 10, then a good packet
        do_reset();
        fill_seq(32, 8'h20);
        drive_pkt(32, GOOD_IP, 0, 0, 0, 11, -1);
        do_reset();
        check("t5_state_after_rst", dbg_state, IDLE);
        fill_seq(32, 0);
        model_pkt(32, 0, 32'd31);
        drive_pkt(32, GOOD_IP, 0, 0, 1, 32, -1);
        idle(4);
        check("t5_pkt_lit", pkt_count, 1);
        check("t5_err_lit", err_count, 0);
        check_counters("t5");

        // Single-byte packet, exact one-word packet, mid-packet config change
        do_reset();
        config_pkt_len = 32'd0;
        fill_seq(1, 8'hAB);
        model_pkt(1, 0, 32'd0);
        check("pin_t6_single", exp_q[0], {3'b011, 8'hAB, 120'h0});
        drive_pkt(1, GOOD_IP, 0, 0, 1, 1, -1);
        config_pkt_len = 32'd15;
        fill_seq(16, 8'hC0);
        model_pkt(16, 0, 32'd15);
        drive_pkt(16, GOOD_IP, 0, 0, 1, 16, -1);
        config_pkt_len = 32'd31;
        fill_seq(32, 8'h60);
        model_pkt(32, 0, 32'd31);
        drive_pkt(32, GOOD_IP, 0, 1, 1, 32, 5);
        config_pkt_len = 32'd31;
        idle(4);
        check("t6_pkt_lit", pkt_count, 3);
        check_counters("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
